// File: rtl/lsu_bus_arbiter.sv
// Two-master round-robin arbiter for a single data-memory/peripheral port.
// One transaction in flight, IDLE -> BUSY -> DONE, with a bus watchdog that forces completion.
module lsu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // M0: core LSU
  input  logic        m0_rready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_strb,
  output logic        m0_rvalid,
  output logic        m0_wready,
  output logic [31:0] m0_rdata,
  // M1: debug/DMA
  input  logic        m1_rready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_strb,
  output logic        m1_rvalid,
  output logic        m1_wready,
  output logic [31:0] m1_rdata,
  // slave port
  output logic        s_rready,
  output logic        s_wvalid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_strb,
  input  logic        s_rvalid,
  input  logic        s_wready,
  input  logic [31:0] s_rdata,
  output logic        bus_err,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;
  logic        grant_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [15:0] to_cnt;

  logic        m0_req;
  logic        m1_req;
  logic        any_req;
  logic        sel;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;

  logic        busy;
  logic        rsp_hit;
  logic        to_hit;
  logic        fin;
  logic [31:0] rd_val;

  // arbitration
  always_comb begin
    m0_req    = m0_rready | m0_wvalid;
    m1_req    = m1_rready | m1_wvalid;
    any_req   = m0_req | m1_req;
    sel       = (m0_req & m1_req) ? ~last_grant : m1_req;
    sel_wr    = sel ? m1_wvalid : m0_wvalid;
    sel_addr  = sel ? m1_addr   : m0_addr;
    sel_wdata = sel ? m1_wdata  : m0_wdata;
    sel_strb  = sel ? m1_strb   : m0_strb;
  end

  // completion: a real slave response on the watchdog cycle takes priority
  always_comb begin
    busy    = (state == BUSY);
    rsp_hit = busy & (wr_q ? s_wready : s_rvalid);
    to_hit  = busy & TO_EN & (to_cnt == TO_LAST) & ~rsp_hit;
    fin     = rsp_hit | to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (fin)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      to_cnt     <= '0;
    end else if (state == IDLE && any_req) begin
      last_grant <= sel;
      grant_q    <= sel;
      wr_q       <= sel_wr;
      addr_q     <= sel_addr;
      wdata_q    <= sel_wdata;
      strb_q     <= sel_strb;
      to_cnt     <= '0;
    end else if (busy) begin
      to_cnt     <= to_cnt + 16'd1;
    end
  end

  // Completion pulses are gated by the owner's request so a withdrawn request drops its pulse.
  always_comb begin
    s_rready  = busy & ~wr_q;
    s_wvalid  = busy & wr_q;
    s_addr    = addr_q;
    s_wdata   = wdata_q;
    s_strb    = strb_q;
    bus_err   = to_hit;
    grant_id  = grant_q;
    rd_val    = to_hit ? ERR_RDATA : s_rdata;

    m0_rvalid = fin & ~grant_q & ~wr_q & m0_rready;
    m0_wready = fin & ~grant_q &  wr_q & m0_wvalid;
    m1_rvalid = fin &  grant_q & ~wr_q & m1_rready;
    m1_wready = fin &  grant_q &  wr_q & m1_wvalid;
    m0_rdata  = m0_rvalid ? rd_val : '0;
    m1_rdata  = m1_rvalid ? rd_val : '0;
  end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Directed bench for lsu_bus_arbiter: scoreboard of expected completions checked by a negedge monitor.
module tb_lsu_bus_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        m0_rready = 1'b0, m0_wvalid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_strb = '0;
  logic        m0_rvalid, m0_wready;
  logic [31:0] m0_rdata;

  logic        m1_rready = 1'b0, m1_wvalid = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_strb = '0;
  logic        m1_rvalid, m1_wready;
  logic [31:0] m1_rdata;

  logic        s_rready, s_wvalid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_rvalid, s_wready;
  logic [31:0] s_rdata;
  logic        bus_err, grant_id;

  always #5 clk = ~clk;

  lsu_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rready(m0_rready), .m0_wvalid(m0_wvalid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_rvalid(m0_rvalid), .m0_wready(m0_wready), .m0_rdata(m0_rdata),
    .m1_rready(m1_rready), .m1_wvalid(m1_wvalid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_rvalid(m1_rvalid), .m1_wready(m1_wready), .m1_rdata(m1_rdata),
    .s_rready(s_rready), .s_wvalid(s_wvalid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_strb(s_strb), .s_rvalid(s_rvalid), .s_wready(s_wready), .s_rdata(s_rdata),
    .bus_err(bus_err), .grant_id(grant_id)
  );

  // slave model: answers slave_lat cycles after its request rises, data = rd_key ^ address
  int          slave_lat    = 0;
  bit          slave_silent = 1'b0;
  logic [31:0] rd_key       = 32'h0BAD_F00D;
  int          scnt         = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   scnt <= 0;
    else if (!(s_rready | s_wvalid)) scnt <= 0;
    else                          scnt <= scnt + 1;
  end

  assign s_rvalid = s_rready & ~slave_silent & (scnt == slave_lat);
  assign s_wready = s_wvalid & ~slave_silent & (scnt == slave_lat);
  assign s_rdata  = rd_key ^ s_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rem0 = 0, rem1 = 0;
  logic [31:0] ra0 = '0, ra1 = '0;
  bit   p0, p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // monitor: every completion pulse pops the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      p0 = m0_rvalid | m0_wready;
      p1 = m1_rvalid | m1_wready;
      if (p0 | p1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, p1, p0}, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("pulse_owner", {30'd0, p1, p0}, cur.m ? 32'd2 : 32'd1);
          chk("pulse_kind", cur.m ? m1_wready : m0_wready, cur.wr);
          chk("grant_id", grant_id, cur.m);
          chk("s_addr", s_addr, cur.addr);
          if (cur.wr) begin
            chk("s_wdata", s_wdata, cur.wdata);
            chk("s_strb", s_strb, cur.strb);
          end else begin
            chk("rdata", cur.m ? m1_rdata : m0_rdata, cur.rdata);
          end
          chk("bus_err", bus_err, cur.err);
          if (cur.lat >= 0) chk("latency", cyc - cur.t0, cur.lat);
        end
      end else begin
        chk("bus_err_idle", bus_err, 1'b0);
      end
    end
  end

  task automatic issue(input bit m, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit err, input int lat);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = strb;
    e.rdata = err ? 32'hDEAD_BEEF : (rd_key ^ addr);
    e.err = err; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    if (!m) begin
      m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
      if (wr) m0_wvalid = 1'b1; else m0_rready = 1'b1;
    end else begin
      m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
      if (wr) m1_wvalid = 1'b1; else m1_rready = 1'b1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // masters drop their request after the pulse, or re-request while rem* > 0
  task automatic run(input int budget);
    int k = 0;
    bit q0, q1;
    while ((m0_rready | m0_wvalid | m1_rready | m1_wvalid) && k < budget) begin
      @(negedge clk);
      k++;
      q0 = m0_rvalid | m0_wready;
      q1 = m1_rvalid | m1_wready;
      #1;
      if (q0) begin
        m0_rready = 1'b0; m0_wvalid = 1'b0;
        if (rem0 > 0) begin rem0--; ra0 = ra0 + 32'd4; issue(1'b0, 1'b0, ra0, '0, 4'hF, 1'b0, -1); end
      end
      if (q1) begin
        m1_rready = 1'b0; m1_wvalid = 1'b0;
        if (rem1 > 0) begin rem1--; ra1 = ra1 + 32'd4; issue(1'b1, 1'b0, ra1, '0, 4'hF, 1'b0, -1); end
      end
    end
    chk("run_timeout", {31'd0, m0_rready | m0_wvalid | m1_rready | m1_wvalid}, 32'd0);
    m0_rready = 1'b0; m0_wvalid = 1'b0; m1_rready = 1'b0; m1_wvalid = 1'b0;
    step(2);
    chk("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_s_wvalid", s_wvalid, 1'b0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_strb", s_strb, 4'd0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(1);

    // simultaneous writes from reset: M0 first, M1 granted three edges later
    slave_lat = 0;
    issue(1'b0, 1'b1, 32'h0000_0200, 32'hAAAA_0001, 4'hF, 1'b0, 1);
    issue(1'b1, 1'b1, 32'h0000_0300, 32'hBBBB_0002, 4'hF, 1'b0, 4);
    run(40);

    // continuous reads from both: strict alternation over 8 transactions
    slave_lat = 1;
    ra0 = 32'h0000_1000; ra1 = 32'h0000_2000; rem0 = 3; rem1 = 3;
    issue(1'b0, 1'b0, ra0, '0, 4'hF, 1'b0, -1);
    issue(1'b1, 1'b0, ra1, '0, 4'hF, 1'b0, -1);
    run(200);

    // single M0 read, slave answers two cycles after request: rdata 0x1234_5678
    slave_lat = 2;
    rd_key = 32'h1234_5778;
    issue(1'b0, 1'b0, 32'h0000_0100, '0, 4'hF, 1'b0, 3);
    run(40);

    // M0 was served last, so this simultaneous pair goes to M1 first
    slave_lat = 0;
    rd_key = 32'h0BAD_F00D;
    issue(1'b1, 1'b1, 32'h0000_0310, 32'hCCCC_0003, 4'hC, 1'b0, 1);
    issue(1'b0, 1'b1, 32'h0000_0210, 32'hDDDD_0004, 4'h3, 1'b0, 4);
    run(40);

    // silent slave: watchdog completes 16 cycles after grant
    slave_silent = 1'b1;
    issue(1'b0, 1'b0, 32'h0000_0500, '0, 4'hF, 1'b1, 16);
    run(60);
    chk("idle_after_timeout", s_rready, 1'b0);

    // response on the watchdog cycle wins
    slave_silent = 1'b0;
    slave_lat = 15;
    issue(1'b0, 1'b0, 32'h0000_0600, '0, 4'hF, 1'b0, 16);
    run(60);

    // withdrawn request: transaction finishes, no pulse reaches M0
    slave_lat = 3;
    m0_addr = 32'h0000_0700; m0_rready = 1'b1;
    step(2);
    m0_rready = 1'b0;
    step(6);
    chk("withdraw_idle", s_rready, 1'b0);
    chk("withdraw_sb", sb.size(), 32'd0);

    // reset in BUSY: outputs clear at once, then M0 wins the first tie
    slave_silent = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0800, '0, 4'hF, 1'b0, -1);
    step(3);
    chk("pre_reset_busy", s_rready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_rready", s_rready, 1'b0);
    chk("midrst_s_addr", s_addr, 32'd0);
    chk("midrst_m1_rvalid", m1_rvalid, 1'b0);
    chk("midrst_grant_id", grant_id, 1'b0);
    m1_rready = 1'b0;
    sb.delete();
    step(2);
    rst_n = 1'b1;
    slave_silent = 1'b0;
    slave_lat = 0;
    issue(1'b0, 1'b0, 32'h0000_0900, '0, 4'hF, 1'b0, 1);
    issue(1'b1, 1'b0, 32'h0000_0A00, '0, 4'hF, 1'b0, 4);
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
